// File: rtl/ipm2l_fifo_fwft_rd_v1_0.sv
// ---------------------------------------------------------------------------
// ipm2l_fifo_fwft_rd_v1_0
//
// First-word-fall-through read adapter for the FIFO core read port. Reads are
// issued to the FIFO only when the skid buffer is guaranteed to have room for
// the returning word, so the fixed RAM read latency is absorbed without ever
// overflowing. The head word is presented as a valid/ready stream and the
// adapter sustains one word per clock under continuous m_ready.
//
// Parameters:
//   c_DATA_WIDTH  data width (equal to the FIFO read data width)
//   c_RD_LATENCY  FIFO read latency in cycles: 1 (no output reg) or 2
//
// Ports:
//   rd_clk        read-side clock
//   rd_rst_n      synchronous active-low reset
//   fifo_rd_en    read enable to FIFO
//   fifo_rd_data  read data from FIFO
//   fifo_rd_empty empty flag from FIFO
//   fifo_rd_oce   output-register clock enable to FIFO (tied to 1)
//   m_data        head word of the stream
//   m_valid       m_data holds a word
//   m_ready       consumer accepts the head word
//   buf_level     words currently held in the skid buffer
//
// Optional feature (macro IPM2L_FWFT_STAT_EN):
//   stat_words    32-bit wrapping count of accepted words
//   stat_stall    32-bit wrapping count of cycles with m_valid & !m_ready
// ---------------------------------------------------------------------------
module ipm2l_fifo_fwft_rd_v1_0 #(
    parameter int c_DATA_WIDTH = 32,
    parameter int c_RD_LATENCY = 1
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst_n,
    output logic                    fifo_rd_en,
    input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_oce,
    output logic [c_DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [1:0]              buf_level
`ifdef IPM2L_FWFT_STAT_EN
    ,
    output logic [31:0]             stat_words,
    output logic [31:0]             stat_stall
`endif
);

    // One slot per read that can be in flight plus one for the word on show.
    localparam int                    c_BUF_DEPTH = c_RD_LATENCY + 1;
    localparam int                    PTR_W       = $clog2(c_BUF_DEPTH);
    localparam logic [PTR_W-1:0]      LAST_PTR    = PTR_W'(c_BUF_DEPTH - 1);
    localparam logic [2:0]            DEPTH3      = 3'(c_BUF_DEPTH);
    localparam logic [1:0]            DEPTH2      = 2'(c_BUF_DEPTH);

    logic [c_DATA_WIDTH-1:0] buf_mem [c_BUF_DEPTH];
    logic [PTR_W-1:0]        wptr;
    logic [PTR_W-1:0]        rptr;
    logic [1:0]              occ;
    logic [1:0]              inflight;
    logic [c_RD_LATENCY-1:0] issue_sr;
    logic                    pop;
    logic                    capture;
    logic [2:0]              demand;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Each bit of issue_sr marks one outstanding read; the oldest one sits at
    // the top and means fifo_rd_data is valid in this cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < c_RD_LATENCY; i++) begin
            inflight = inflight + {1'b0, issue_sr[i]};
        end
    end

    // A read may be issued only if every slot is still covered after this
    // cycle's pop. The reset gate keeps the FIFO idle while it is being reset.
    always_comb begin
        capture     = issue_sr[c_RD_LATENCY-1];
        m_valid     = (occ != 2'd0);
        pop         = m_valid & m_ready;
        demand      = {1'b0, occ} + {1'b0, inflight} - {2'b0, pop};
        fifo_rd_en  = rd_rst_n & ~fifo_rd_empty & (demand < DEPTH3);
        fifo_rd_oce = 1'b1;
        m_data      = buf_mem[rptr];
        buf_level   = occ;
    end

    // Clearing issue_sr on reset discards data from reads issued before reset.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            issue_sr <= '0;
            occ      <= '0;
            wptr     <= '0;
            rptr     <= '0;
            for (int i = 0; i < c_BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            issue_sr <= (issue_sr << 1) | c_RD_LATENCY'(fifo_rd_en);
            if (capture) begin
                buf_mem[wptr] <= fifo_rd_data;
                wptr          <= next_ptr(wptr);
            end
            if (pop) begin
                rptr <= next_ptr(rptr);
            end
            occ <= occ + {1'b0, capture} - {1'b0, pop};
        end
    end

    // The issue rule makes this unreachable; a hit means the credit math broke.
    always_ff @(posedge rd_clk) begin
        if (rd_rst_n) begin
            assert (!(capture && !pop && (occ == DEPTH2)));
        end
    end

`ifdef IPM2L_FWFT_STAT_EN
    // Free-running statistics, wrapping naturally at 2^32.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            stat_words <= '0;
            stat_stall <= '0;
        end else begin
            if (pop) begin
                stat_words <= stat_words + 32'd1;
            end
            if (m_valid && !m_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_ipm2l_fifo_fwft_rd_v1_0.sv
// Testbench for ipm2l_fifo_fwft_rd_v1_0. Two instances (read latency 1 and 2)
// share the input stimulus; lat selects which one the reference model follows.
// The model holds the FIFO contents and the expected output order as queues,
// and tracks buffer occupancy from the timestamps of issued reads.
module tb_ipm2l_fifo_fwft_rd_v1_0;

    logic        clk = 1'b0;
    logic        rd_rst_n;
    logic        m_ready;
    logic        fifo_rd_empty;
    logic [31:0] fifo_rd_data;

    logic        en1, en2, oce1, oce2, mv1, mv2;
    logic [31:0] md1, md2;
    logic [1:0]  bl1, bl2;
`ifdef IPM2L_FWFT_STAT_EN
    logic [31:0] sw1, sw2, ss1, ss2;
    logic [31:0] sw, ss;
`endif

    logic        en, oce, mv;
    logic [31:0] md;
    logic [1:0]  bl;
    int          lat;

    // Model state
    logic [31:0] fq[$];
    logic [31:0] sb[$];
    int          issQ[$];
    int          occM;
    logic [31:0] pipe1, pipe2;
    int          cyc;
    logic        prevStall;
    logic [31:0] prevData;

    // Counters
    int errCnt, chkCnt;
    int issueCnt, popCnt;
    int firstValid, lastPopCyc, gapCnt, stallCnt, maxLevel, phasePops, phaseIssues;

    always #5 clk = ~clk;

    ipm2l_fifo_fwft_rd_v1_0 #(.c_DATA_WIDTH(32), .c_RD_LATENCY(1)) u_dut_lat1 (
        .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_rd_en(en1), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_oce(oce1), .m_data(md1), .m_valid(mv1),
        .m_ready(m_ready), .buf_level(bl1)
`ifdef IPM2L_FWFT_STAT_EN
        , .stat_words(sw1), .stat_stall(ss1)
`endif
    );

    ipm2l_fifo_fwft_rd_v1_0 #(.c_DATA_WIDTH(32), .c_RD_LATENCY(2)) u_dut_lat2 (
        .rd_clk(clk), .rd_rst_n(rd_rst_n), .fifo_rd_en(en2), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_oce(oce2), .m_data(md2), .m_valid(mv2),
        .m_ready(m_ready), .buf_level(bl2)
`ifdef IPM2L_FWFT_STAT_EN
        , .stat_words(sw2), .stat_stall(ss2)
`endif
    );

    always_comb begin
        en  = (lat == 2) ? en2  : en1;
        oce = (lat == 2) ? oce2 : oce1;
        mv  = (lat == 2) ? mv2  : mv1;
        md  = (lat == 2) ? md2  : md1;
        bl  = (lat == 2) ? bl2  : bl1;
`ifdef IPM2L_FWFT_STAT_EN
        sw  = (lat == 2) ? sw2  : sw1;
        ss  = (lat == 2) ? ss2  : ss1;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        chkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h (lat=%0d cycle=%0d)",
                     tag, observed, expected, lat, cyc);
        end
    endtask

    task automatic writeWord(input logic [31:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    task automatic startPhase();
        firstValid  = -1;
        lastPopCyc  = -1;
        gapCnt      = 0;
        stallCnt    = 0;
        maxLevel    = 0;
        phasePops   = 0;
        phaseIssues = 0;
    endtask

    // One clock cycle: drive inputs, check at mid-cycle, advance the model.
    task automatic applyStimulus(input logic rstIn, input logic readyIn);
        int          depth;
        int          inflightM;
        logic        popM;
        logic        expEn;
        logic        capNow;
        logic [31:0] rdWord;
        logic [31:0] expWord;
        depth         = lat + 1;
        rd_rst_n      = ~rstIn;
        m_ready       = readyIn;
        fifo_rd_empty = (fq.size() == 0);
        fifo_rd_data  = (lat == 1) ? pipe1 : pipe2;
        rdWord        = 32'hBAD0_BAD0;
        #4;
        checkOutput("fifo_rd_oce", 32'(oce), 32'd1);
        popM = (occM != 0) && readyIn;
        if (rstIn) begin
            checkOutput("rd_en_in_reset", 32'(en), 32'd0);
        end else begin
            inflightM = issQ.size();
            expEn = !fifo_rd_empty && ((occM + inflightM - (popM ? 1 : 0)) < depth);
            checkOutput("fifo_rd_en", 32'(en), 32'(expEn));
            checkOutput("m_valid", 32'(mv), 32'(occM != 0));
            checkOutput("buf_level", 32'(bl), 32'(occM));
            checkOutput("outstanding_bound", 32'((issueCnt - popCnt) <= depth), 32'd1);
            if (prevStall) begin
                checkOutput("stall_data", md, prevData);
                checkOutput("stall_valid", 32'(mv), 32'd1);
            end
            if (mv && readyIn) begin
                if (sb.size() == 0) begin
                    checkOutput("pop_without_word", 32'd1, 32'd0);
                end else begin
                    expWord = sb.pop_front();
                    checkOutput("m_data", md, expWord);
                end
                popCnt++;
                phasePops++;
                if (lastPopCyc >= 0 && (cyc - lastPopCyc) > 1) gapCnt++;
                lastPopCyc = cyc;
            end
            if (mv && firstValid < 0) firstValid = cyc;
            if (mv && !readyIn) stallCnt++;
            if (int'(bl) > maxLevel) maxLevel = int'(bl);
        end

        if (rstIn) begin
            fq.delete();
            sb.delete();
            issQ.delete();
            occM      = 0;
            prevStall = 1'b0;
            issueCnt  = 0;
            popCnt    = 0;
        end else begin
            capNow = (issQ.size() > 0) && (issQ[0] + lat == cyc);
            if (capNow) begin
                void'(issQ.pop_front());
                occM++;
            end
            if (popM) occM--;
            if (en) begin
                issueCnt++;
                phaseIssues++;
                if (fq.size() > 0) rdWord = fq.pop_front();
                issQ.push_back(cyc);
            end
            prevStall = mv && !readyIn;
            prevData  = md;
        end
        pipe2 = pipe1;
        if (en) pipe1 = rdWord;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll(input string tag, input int budget);
        for (int k = 0; k < budget && (sb.size() > 0 || occM > 0 || issQ.size() > 0); k++) begin
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput(tag, sb.size(), 32'd0);
    endtask

    task automatic randomRun();
        int written;
        startPhase();
        written = 0;
        for (int k = 0; k < 8000 && (written < 1000 || sb.size() > 0); k++) begin
            if (written < 1000 && $urandom_range(0, 99) < 60) begin
                writeWord($urandom);
                written++;
            end
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        end
        checkOutput("random_left", sb.size(), 32'd0);
        checkOutput("random_pops", phasePops, 32'd1000);
    endtask

    initial begin
        int fallCyc;
        int stallIssues;
        errCnt = 0; chkCnt = 0; cyc = 0; occM = 0;
        issueCnt = 0; popCnt = 0; prevStall = 1'b0; prevData = '0;
        pipe1 = 32'h0; pipe2 = 32'h0;
        lat = 1;
        rd_rst_n = 1'b0; m_ready = 1'b0; fifo_rd_empty = 1'b1; fifo_rd_data = '0;
        startPhase();
        @(posedge clk);
        #1;

        // ---------------- latency 1 ----------------
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_valid", 32'(mv), 32'd0);
        checkOutput("reset_level", 32'(bl), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // First-word latency and full-rate streaming of 0x10..0x17
        startPhase();
        fallCyc = cyc;
        for (int i = 0; i < 8; i++) writeWord(32'h10 + 32'(i));
        for (int k = 0; k < 14; k++) applyStimulus(1'b0, 1'b1);
        checkOutput("first_word_latency", firstValid - fallCyc, 32'd2);
        checkOutput("burst_beats", phasePops, 32'd8);
        checkOutput("burst_gaps", gapCnt, 32'd0);
        checkOutput("burst_end_valid", 32'(mv), 32'd0);

        // Capture into the last free slot together with a pop
        writeWord(32'hA000_0001);
        for (int k = 0; k < 10 && bl != 2'd1; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("last_slot_pre", 32'(bl), 32'd1);
        writeWord(32'hA000_0002);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("last_slot_level", 32'(bl), 32'd1);
        checkOutput("last_slot_data", md, 32'hA000_0002);
        drainAll("last_slot_drain", 20);

        randomRun();

        // ---------------- latency 2 ----------------
        lat = 2;
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset2_valid", 32'(mv), 32'd0);

        // Backpressure: 20 stalled cycles, then release
        startPhase();
        for (int i = 0; i < 16; i++) writeWord(32'h200 + 32'(i));
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b0);
        stallIssues = phaseIssues;
        checkOutput("stall_issues", stallIssues, 32'd3);
        checkOutput("stall_max_level", maxLevel, 32'd3);
        drainAll("backpressure_drain", 60);
        checkOutput("backpressure_pops", phasePops, 32'd16);
        checkOutput("backpressure_gaps", gapCnt, 32'd0);

        // Reset with two reads in flight and one word buffered
        for (int i = 0; i < 5; i++) writeWord(32'h300 + 32'(i));
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_level", 32'(bl), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_reset_valid", 32'(mv), 32'd0);
        checkOutput("post_reset_level", 32'(bl), 32'd0);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b1);
        checkOutput("no_stale_capture", 32'(bl), 32'd0);

        randomRun();

`ifdef IPM2L_FWFT_STAT_EN
        // Statistics: 100 pops with exactly 37 stall cycles
        applyStimulus(1'b1, 1'b0);
        checkOutput("stat_words_rst", sw, 32'd0);
        checkOutput("stat_stall_rst", ss, 32'd0);
        startPhase();
        for (int i = 0; i < 100; i++) writeWord($urandom);
        for (int k = 0; k < 600 && sb.size() > 0; k++) begin
            applyStimulus(1'b0, ~(mv && stallCnt < 37 && (cyc % 2 == 0)));
        end
        checkOutput("stat_stall_cnt", stallCnt, 32'd37);
        checkOutput("stat_words", sw, 32'd100);
        checkOutput("stat_stall", ss, 32'd37);
        applyStimulus(1'b1, 1'b0);
        checkOutput("stat_words_clr", sw, 32'd0);
        checkOutput("stat_stall_clr", ss, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
